debug_dump_sequencer: RTL and testbench

//  Sequences the post-halt/post-step state dump of the MIPS core to the UART TX.
//  On a start pulse it walks PC, cycle count, all GPRs and all data-memory words.
//  It drives the register and memory read selects and serializes each 32-bit word MSB-byte-first.

---
 rtl/debug_dump_sequencer_pkg.sv | 31 +++
 rtl/debug_dump_sequencer_word_byte_serializer.sv | 55 +++++
 rtl/debug_dump_sequencer.sv | 145 ++++++++++++++
 tb/tb_debug_dump_sequencer.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_dump_sequencer_pkg.sv
// Types and constants shared by the debug dump sequencer, its serializer and the
// debug controller that issues the ASCII commands over the UART.
package debug_dump_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_SEND,
        ST_WAIT,
        ST_ADVANCE,
        ST_DONE
    } dump_state_t;

    typedef enum logic [1:0] {
        SEC_PC,
        SEC_CLK,
        SEC_REGS,
        SEC_MEM
    } section_t;

    // Command bytes understood by the debug controller.
    localparam logic [7:0] CMD_RUN   = 8'h72;
    localparam logic [7:0] CMD_STEP  = 8'h73;
    localparam logic [7:0] CMD_HALT  = 8'h68;
    localparam logic [7:0] CMD_DUMP  = 8'h64;
    localparam logic [7:0] CMD_RESET = 8'h78;

    localparam int MEM_WORD_BYTES = 4;

endpackage

// File: rtl/debug_dump_sequencer_word_byte_serializer.sv
// Holds one word and hands it to the UART TX a byte at a time, most significant
// byte first, reporting each accepted byte and the end of the word.
module debug_dump_sequencer_word_byte_serializer
    import debug_dump_sequencer_pkg::*;
#(
    parameter int NBITS     = 32,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [NBITS-1:0]     word_in,
    input  logic                 send,
    input  logic                 wait_active,
    input  logic                 tx_done,
    output logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_start,
    output logic                 byte_sent,
    output logic                 word_sent
);

    localparam int BYTES = NBITS / DATA_BITS;
    localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [NBITS-1:0]     word;
    logic [CNT_W-1:0]     byte_cnt;
    logic [DATA_BITS-1:0] last_byte;

    // The byte on the wire is shown live during SEND and then held from last_byte,
    // so it stays put after the word register has shifted on.
    assign tx_start  = send;
    assign tx_data   = send ? word[NBITS-1 -: DATA_BITS] : last_byte;
    assign byte_sent = wait_active & tx_done;
    assign word_sent = byte_sent & (byte_cnt == CNT_W'(BYTES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word      <= '0;
            byte_cnt  <= '0;
            last_byte <= '0;
        end else begin
            if (load) begin
                word     <= word_in;
                byte_cnt <= '0;
            end else if (byte_sent) begin
                word     <= word << DATA_BITS;
                byte_cnt <= byte_cnt + 1'b1;
            end
            if (send) begin
                last_byte <= word[NBITS-1 -: DATA_BITS];
            end
        end
    end

endmodule

// File: rtl/debug_dump_sequencer.sv
// Walks PC, cycle count, every GPR and every data-memory word after a halt or step,
// driving the read selects and feeding each word to the UART byte serializer.
module debug_dump_sequencer
    import debug_dump_sequencer_pkg::*;
#(
    parameter int NBITS         = 32,
    parameter int DATA_BITS     = 8,
    parameter int REG_COUNT     = 32,
    parameter int DATA_MEM_SIZE = 256
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_start,
    output logic                         o_busy,
    output logic                         o_done,
    input  logic [NBITS-1:0]             i_mips_pc,
    input  logic [NBITS-1:0]             i_mips_clk_count,
    output logic [$clog2(REG_COUNT)-1:0] o_mips_reg_sel,
    input  logic [NBITS-1:0]             i_mips_reg_data,
    output logic [NBITS-1:0]             o_mips_mem_addr,
    input  logic [NBITS-1:0]             i_mips_mem_data,
    output logic [DATA_BITS-1:0]         o_tx_data,
    output logic                         o_tx_start,
    input  logic                         i_tx_done
);

    localparam int                      SEL_W     = $clog2(REG_COUNT);
    localparam logic [SEL_W-1:0]        LAST_REG  = SEL_W'(REG_COUNT - 1);
    localparam logic [NBITS-1:0]        LAST_ADDR = NBITS'(DATA_MEM_SIZE - MEM_WORD_BYTES);

    dump_state_t          state, next_state;
    section_t             section;
    logic [SEL_W-1:0]     reg_sel;
    logic [NBITS-1:0]     mem_addr;
    logic [NBITS-1:0]     load_word;
    logic                 byte_sent, word_sent, last_word;

    assign o_busy          = (state != ST_IDLE);
    assign o_done          = (state == ST_DONE);
    assign o_mips_reg_sel  = reg_sel;
    assign o_mips_mem_addr = mem_addr;
    assign last_word       = (section == SEC_MEM) && (mem_addr == LAST_ADDR);

    always_comb begin
        load_word = '0;
        case (section)
            SEC_PC:   load_word = i_mips_pc;
            SEC_CLK:  load_word = i_mips_clk_count;
            SEC_REGS: load_word = i_mips_reg_data;
            SEC_MEM:  load_word = i_mips_mem_data;
            default:  load_word = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:    if (i_start) next_state = ST_FETCH;
            ST_FETCH:   next_state = ST_LOAD;
            ST_LOAD:    next_state = ST_SEND;
            ST_SEND:    next_state = ST_WAIT;
            ST_WAIT: begin
                if (word_sent) begin
                    next_state = ST_ADVANCE;
                end else if (byte_sent) begin
                    next_state = ST_SEND;
                end
            end
            ST_ADVANCE: next_state = last_word ? ST_DONE : ST_FETCH;
            ST_DONE:    next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    // Selects only move in ADVANCE, so the read data seen in LOAD always matches
    // a select that has been stable for the whole FETCH cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            section  <= SEC_PC;
            reg_sel  <= '0;
            mem_addr <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        section  <= SEC_PC;
                        reg_sel  <= '0;
                        mem_addr <= '0;
                    end
                end
                ST_ADVANCE: begin
                    case (section)
                        SEC_PC:  section <= SEC_CLK;
                        SEC_CLK: section <= SEC_REGS;
                        SEC_REGS: begin
                            if (reg_sel == LAST_REG) begin
                                section <= SEC_MEM;
                            end else begin
                                reg_sel <= reg_sel + 1'b1;
                            end
                        end
                        SEC_MEM: begin
                            if (mem_addr != LAST_ADDR) begin
                                mem_addr <= mem_addr + NBITS'(MEM_WORD_BYTES);
                            end
                        end
                        default: section <= SEC_PC;
                    endcase
                end
                ST_DONE: begin
                    section  <= SEC_PC;
                    reg_sel  <= '0;
                    mem_addr <= '0;
                end
                default: ;
            endcase
        end
    end

    debug_dump_sequencer_word_byte_serializer #(
        .NBITS     (NBITS),
        .DATA_BITS (DATA_BITS)
    ) u_serializer (
        .clk         (i_clk),
        .rst_n       (i_rst_n),
        .load        (state == ST_LOAD),
        .word_in     (load_word),
        .send        (state == ST_SEND),
        .wait_active (state == ST_WAIT),
        .tx_done     (i_tx_done),
        .tx_data     (o_tx_data),
        .tx_start    (o_tx_start),
        .byte_sent   (byte_sent),
        .word_sent   (word_sent)
    );

endmodule

// File: tb/tb_debug_dump_sequencer.sv
// Scoreboard bench: expected dump bytes are queued at each start and popped by
// monitors whenever a sequencer raises o_tx_start; a small second instance covers tiny sizes.
module tb_debug_dump_sequencer;

    localparam int REG_COUNT   = 32;
    localparam int MEM_WORDS   = 64;
    localparam int SMALL_REGS  = 4;
    localparam int SMALL_WORDS = 2;
    localparam int TIMEOUT     = 20000;

    typedef logic [7:0] byte_q_t[$];
    typedef logic [31:0] word_q_t[$];

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cycle_cnt = 0;
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    // Full-size instance
    logic        start = 1'b0, busy, done, tx_start, tx_done;
    logic        model_done = 1'b0, spur_done = 1'b0;
    logic [31:0] pc = '0, clk_count = '0, reg_data = '0, mem_data = '0, mem_addr;
    logic [4:0]  reg_sel;
    logic [7:0]  tx_data;
    logic [31:0] regs[REG_COUNT];
    logic [31:0] mem[MEM_WORDS];
    byte_q_t     exp_q;
    int          tx_delay = 10;
    int          byte_idx = 0, byte_base = 0, done_count = 0, last_done_cycle = 0;
    logic [7:0]  last_sent = '0;
    logic        done_prev = 1'b0;

    assign tx_done = model_done | spur_done;

    debug_dump_sequencer dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_start          (start),
        .o_busy           (busy),
        .o_done           (done),
        .i_mips_pc        (pc),
        .i_mips_clk_count (clk_count),
        .o_mips_reg_sel   (reg_sel),
        .i_mips_reg_data  (reg_data),
        .o_mips_mem_addr  (mem_addr),
        .i_mips_mem_data  (mem_data),
        .o_tx_data        (tx_data),
        .o_tx_start       (tx_start),
        .i_tx_done        (tx_done)
    );

    // Small instance
    logic        small_start = 1'b0, small_busy, small_done, small_tx_start;
    logic        small_tx_done = 1'b0;
    logic [1:0]  small_reg_sel;
    logic [31:0] small_mem_addr, small_reg_data = '0, small_mem_data = '0;
    logic [7:0]  small_tx_data;
    logic [31:0] small_regs[SMALL_REGS];
    logic [31:0] small_mem[SMALL_WORDS];
    byte_q_t     small_exp_q;
    int          small_done_count = 0;
    logic        small_done_prev = 1'b0;

    debug_dump_sequencer #(
        .REG_COUNT     (4),
        .DATA_MEM_SIZE (8)
    ) dut_small (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_start          (small_start),
        .o_busy           (small_busy),
        .o_done           (small_done),
        .i_mips_pc        (pc),
        .i_mips_clk_count (clk_count),
        .o_mips_reg_sel   (small_reg_sel),
        .i_mips_reg_data  (small_reg_data),
        .o_mips_mem_addr  (small_mem_addr),
        .i_mips_mem_data  (small_mem_data),
        .o_tx_data        (small_tx_data),
        .o_tx_start       (small_tx_start),
        .i_tx_done        (small_tx_done)
    );

    // Synchronous-read register file and data memory
    always @(posedge clk) begin
        reg_data       <= regs[reg_sel];
        mem_data       <= mem[6'(mem_addr >> 2)];
        small_reg_data <= small_regs[small_reg_sel];
        small_mem_data <= small_mem[1'(small_mem_addr >> 2)];
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)",
                     name, actual, expected, cycle_cnt);
        end
    endtask

    // Reference model: a dump is the word list PC, CLK, regs, mem, each split MSB byte first.
    function automatic byte_q_t dump_bytes(input word_q_t words);
        byte_q_t q;
        foreach (words[i]) begin
            for (int b = 3; b >= 0; b--) q.push_back(words[i][b*8 +: 8]);
        end
        return q;
    endfunction

    function automatic byte_q_t expected_full();
        word_q_t w;
        w.push_back(pc);
        w.push_back(clk_count);
        foreach (regs[i]) w.push_back(regs[i]);
        foreach (mem[i]) w.push_back(mem[i]);
        return dump_bytes(w);
    endfunction

    function automatic byte_q_t expected_small();
        word_q_t w;
        w.push_back(pc);
        w.push_back(clk_count);
        foreach (small_regs[i]) w.push_back(small_regs[i]);
        foreach (small_mem[i]) w.push_back(small_mem[i]);
        return dump_bytes(w);
    endfunction

    // UART TX models: done pulse tx_delay cycles after each start pulse
    initial begin
        forever begin
            @(negedge clk);
            if (tx_start) begin
                repeat (tx_delay) @(posedge clk);
                #1 model_done = 1'b1;
                @(posedge clk);
                #1 model_done = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (small_tx_start) begin
                repeat (3) @(posedge clk);
                #1 small_tx_done = 1'b1;
                @(posedge clk);
                #1 small_tx_done = 1'b0;
            end
        end
    end

    // Monitor for the full-size instance
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last_sent = '0;
                done_prev = 1'b0;
            end else begin
                if (tx_start) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL extra_byte: got 0x%02h, expected no byte", tx_data);
                    end else begin
                        check_output("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
                    end
                    last_sent = tx_data;
                    byte_idx++;
                end
                if (tx_done && busy) check_output("tx_data_hold", 32'(tx_data), 32'(last_sent));
                if (tx_done) last_done_cycle = cycle_cnt;
                if (done) begin
                    check_output("done_latency", cycle_cnt - last_done_cycle, 2);
                    check_output("bytes_left", exp_q.size(), 0);
                    check_output("final_reg_sel", 32'(reg_sel), REG_COUNT - 1);
                    check_output("final_mem_addr", mem_addr, 252);
                    done_count++;
                end
                if (done_prev) begin
                    check_output("busy_after_done", 32'(busy), 0);
                    check_output("reg_sel_cleared", 32'(reg_sel), 0);
                    check_output("mem_addr_cleared", mem_addr, 0);
                end
                done_prev = done;
            end
        end
    end

    // Monitor for the small instance
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (small_tx_start) begin
                    if (small_exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL small_extra_byte: got 0x%02h, expected no byte",
                                 small_tx_data);
                    end else begin
                        check_output("small_tx_byte", 32'(small_tx_data),
                                     32'(small_exp_q.pop_front()));
                    end
                end
                if (small_done) begin
                    check_output("small_bytes_left", small_exp_q.size(), 0);
                    check_output("small_last_reg_sel", 32'(small_reg_sel), 3);
                    check_output("small_last_mem_addr", small_mem_addr, 4);
                    small_done_count++;
                end
                if (small_done_prev) begin
                    check_output("small_reg_sel_cleared", 32'(small_reg_sel), 0);
                    check_output("small_mem_addr_cleared", small_mem_addr, 0);
                    check_output("small_busy_after_done", 32'(small_busy), 0);
                end
                small_done_prev = small_done;
            end
        end
    end

    task automatic randomize_state();
        pc        = $urandom;
        clk_count = $urandom;
        foreach (regs[i]) regs[i] = $urandom;
        foreach (mem[i]) mem[i] = $urandom;
    endtask

    // Queue the expected stream, pulse start and check the start-up latency.
    task automatic start_dump(input bit spurious_in_fetch);
        exp_q     = expected_full();
        byte_base = byte_idx;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        if (spurious_in_fetch) spur_done = 1'b1;
        @(negedge clk);
        check_output("busy_cycle1", 32'(busy), 1);
        check_output("tx_start_cycle1", 32'(tx_start), 0);
        @(posedge clk);
        #1 spur_done = 1'b0;
        @(negedge clk);
        check_output("tx_start_cycle2", 32'(tx_start), 0);
        @(negedge clk);
        check_output("tx_start_cycle3", 32'(tx_start), 1);
    endtask

    task automatic wait_for_bytes(input int n);
        int waited = 0;
        while ((byte_idx - byte_base) < n && waited < TIMEOUT) begin
            @(negedge clk);
            waited++;
        end
        check_output("bytes_reached", 32'((byte_idx - byte_base) >= n), 1);
    endtask

    task automatic wait_done(input int prev);
        int waited = 0;
        while (done_count == prev && waited < TIMEOUT) begin
            @(negedge clk);
            waited++;
        end
        repeat (20) @(negedge clk);
        check_output("done_count", done_count, prev + 1);
        check_output("dump_bytes", byte_idx - byte_base, 392);
    endtask

    initial begin
        int prev;
        int waited;
        foreach (regs[i]) regs[i] = 32'(i);
        foreach (mem[i]) mem[i] = 32'hA000_0000 | 32'(i * 4);
        foreach (small_regs[i]) small_regs[i] = '0;
        foreach (small_mem[i]) small_mem[i] = '0;
        pc        = 32'h0000_0040;
        clk_count = 32'h0000_0123;

        repeat (3) @(posedge clk);
        #1;
        check_output("reset_busy", 32'(busy), 0);
        check_output("reset_done", 32'(done), 0);
        check_output("reset_tx_start", 32'(tx_start), 0);
        check_output("reset_tx_data", 32'(tx_data), 0);
        check_output("reset_reg_sel", 32'(reg_sel), 0);
        check_output("reset_mem_addr", mem_addr, 0);
        check_output("reset_small_busy", 32'(small_busy), 0);
        rst_n = 1'b1;

        // Dump 1: fixed image, spurious done in IDLE and FETCH, ignored restart at byte 100
        $display("[TB] dump 1: fixed image");
        repeat (2) @(posedge clk);
        #1 spur_done = 1'b1;
        @(posedge clk);
        #1 spur_done = 1'b0;
        prev = done_count;
        start_dump(1'b1);
        wait_for_bytes(100);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(prev);

        // Dump 2: random image, reset at byte 200
        $display("[TB] dump 2: reset mid-dump");
        randomize_state();
        tx_delay = $urandom_range(1, 12);
        prev = done_count;
        start_dump(1'b0);
        wait_for_bytes(200);
        @(posedge clk);
        #1 rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_output("async_busy", 32'(busy), 0);
        check_output("async_tx_start", 32'(tx_start), 0);
        check_output("async_tx_data", 32'(tx_data), 0);
        check_output("async_reg_sel", 32'(reg_sel), 0);
        check_output("async_mem_addr", mem_addr, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (30) @(posedge clk);
        check_output("no_done_after_abort", done_count, prev);

        // Dumps 3 and 4: random images and TX speeds
        for (int d = 0; d < 2; d++) begin
            $display("[TB] dump %0d: random image", d + 3);
            randomize_state();
            tx_delay = (d == 0) ? $urandom_range(1, 12) : 1;
            prev = done_count;
            start_dump(1'b0);
            wait_done(prev);
        end

        // Small instance: 8 words / 32 bytes
        $display("[TB] small instance dump");
        randomize_state();
        foreach (small_regs[i]) small_regs[i] = $urandom;
        foreach (small_mem[i]) small_mem[i] = $urandom;
        small_exp_q = expected_small();
        check_output("small_model_len", small_exp_q.size(), 32);
        @(posedge clk);
        #1 small_start = 1'b1;
        @(posedge clk);
        #1 small_start = 1'b0;
        waited = 0;
        while (small_done_count == 0 && waited < TIMEOUT) begin
            @(negedge clk);
            waited++;
        end
        repeat (5) @(negedge clk);
        check_output("small_done_count", small_done_count, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
